// File: rtl/otter_iobus_timer.sv
// Memory-mapped countdown timer for the OTTER IO bus: CTRL/LOAD/COUNT/STATUS window,
// prescaled tick, one-shot or auto-reload expiry raising a level interrupt.
//
//   state | meaning
//   IDLE  | CTRL.EN=0; COUNT and prescaler frozen
//   RUN   | CTRL.EN=1; prescaler advancing, COUNT decrements on each tick
//   (expiry is an action taken on the tick that finds COUNT=0, not a held state)
module otter_iobus_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h1100_0100,
  parameter int unsigned PRESCALE  = 50
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_IN,
  output logic        HIT,
  output logic        INTR
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  localparam logic [1:0] SEL_CTRL   = 2'd0;
  localparam logic [1:0] SEL_LOAD   = 2'd1;
  localparam logic [1:0] SEL_COUNT  = 2'd2;
  localparam logic [1:0] SEL_STATUS = 2'd3;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state_q, state_d;
  logic          auto_q, auto_d;
  logic          ie_q, ie_d;
  logic          pend_q, pend_d;
  logic [31:0]   load_q, load_d;
  logic [31:0]   count_q, count_d;
  logic [PW-1:0] presc_q, presc_d;

  logic [31:0] offset;
  logic [1:0]  reg_sel;
  logic        wr_hit;
  logic        tick;
  logic        expire;

  // Byte offset into the window with the sub-word address bits dropped.
  assign offset  = (IOBUS_ADDR & ~32'h3) - BASE_ADDR;
  assign HIT     = (offset < 32'd16);
  assign reg_sel = offset[3:2];
  assign wr_hit  = IOBUS_WR & HIT;

  assign tick   = (state_q == RUN) && (presc_q == PRESC_LAST);
  assign expire = tick && (count_q == 32'd0);

  assign INTR = pend_q & ie_q;

  always_comb begin
    IOBUS_IN = 32'd0;
    if (HIT && !RESET) begin
      case (reg_sel)
        SEL_CTRL:   IOBUS_IN = {29'd0, ie_q, auto_q, (state_q == RUN)};
        SEL_LOAD:   IOBUS_IN = load_q;
        SEL_COUNT:  IOBUS_IN = count_q;
        SEL_STATUS: IOBUS_IN = {31'd0, pend_q};
        default:    IOBUS_IN = 32'd0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    auto_d  = auto_q;
    ie_d    = ie_q;
    pend_d  = pend_q;
    load_d  = load_q;
    count_d = count_q;
    presc_d = presc_q;

    // W1C is applied before the timer so a same-edge expiry still sets PEND.
    if (wr_hit && (reg_sel == SEL_STATUS) && IOBUS_OUT[0]) begin
      pend_d = 1'b0;
    end

    if (state_q == RUN) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        if (count_q != 32'd0) begin
          count_d = count_q - 32'd1;
        end else begin
          pend_d = 1'b1;
          if (auto_q) begin
            count_d = load_q;
          end else begin
            state_d = IDLE;
          end
        end
      end
    end

    // Bus writes come last so they override the timer's own updates.
    if (wr_hit) begin
      case (reg_sel)
        SEL_CTRL: begin
          state_d = IOBUS_OUT[0] ? RUN : IDLE;
          auto_d  = IOBUS_OUT[1];
          ie_d    = IOBUS_OUT[2];
        end
        SEL_LOAD: begin
          load_d  = IOBUS_OUT;
          count_d = IOBUS_OUT;
          presc_d = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      auto_q  <= 1'b0;
      ie_q    <= 1'b0;
      pend_q  <= 1'b0;
      load_q  <= 32'd0;
      count_q <= 32'd0;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      auto_q  <= auto_d;
      ie_q    <= ie_d;
      pend_q  <= pend_d;
      load_q  <= load_d;
      count_q <= count_d;
      presc_q <= presc_d;
    end
  end

endmodule

// File: tb/tb_otter_iobus_timer.sv
// Directed and randomized bench for otter_iobus_timer against a cycle-level
// behavioural model of the register map and timer rules.
module tb_otter_iobus_timer;

  localparam logic [31:0] BASE = 32'h1100_0100;
  localparam int          P    = 4;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] IOBUS_ADDR = BASE;
  logic [31:0] IOBUS_OUT = 32'd0;
  logic        IOBUS_WR = 1'b0;
  logic [31:0] IOBUS_IN;
  logic        HIT;
  logic        INTR;

  int n_assert = 0;
  int n_fail   = 0;

  // behavioural model state
  bit          m_en, m_auto, m_ie, m_pend;
  logic [31:0] m_load, m_count;
  int          m_presc;

  otter_iobus_timer #(.BASE_ADDR(BASE), .PRESCALE(P)) dut (
    .CLK(CLK), .RESET(RESET), .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_OUT(IOBUS_OUT),
    .IOBUS_WR(IOBUS_WR), .IOBUS_IN(IOBUS_IN), .HIT(HIT), .INTR(INTR)
  );

  always #10 CLK = ~CLK;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_auto = 0; m_ie = 0; m_pend = 0;
    m_load = 0; m_count = 0; m_presc = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    logic [31:0] off;
    off = (addr & ~32'h3) - BASE;
    if (off >= 32'd16) return 32'd0;
    case (off / 4)
      0: return {29'd0, m_ie, m_auto, m_en};
      1: return m_load;
      2: return m_count;
      default: return {31'd0, m_pend};
    endcase
  endfunction

  // One clock edge of the timer rules, using values from before the edge.
  task automatic model_edge(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] off;
    bit tick, exp_now;
    bit n_en, n_pend;
    logic [31:0] n_count;
    int n_presc;
    off     = (addr & ~32'h3) - BASE;
    tick    = m_en && (m_presc == P - 1);
    exp_now = tick && (m_count == 0);
    n_en    = m_en;
    n_pend  = m_pend;
    n_count = m_count;
    n_presc = m_en ? (m_presc + 1) % P : m_presc;
    if (tick && m_count > 0) n_count = m_count - 1;
    if (exp_now) begin
      n_pend = 1;
      if (m_auto) n_count = m_load; else n_en = 0;
    end
    if (wr && off < 16) begin
      case (off / 4)
        0: begin n_en = data[0]; m_auto = data[1]; m_ie = data[2]; end
        1: begin m_load = data; n_count = data; n_presc = 0; end
        3: if (data[0] && !exp_now) n_pend = 0;
        default: ;
      endcase
    end
    m_en = n_en; m_pend = n_pend; m_count = n_count; m_presc = n_presc;
  endtask

  task automatic step(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    @(negedge CLK);
    IOBUS_ADDR = addr; IOBUS_OUT = data; IOBUS_WR = wr;
    @(posedge CLK);
    model_edge(wr, addr, data);
    #1;
    IOBUS_WR = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, BASE + 32'h8, 32'd0);
  endtask

  task automatic rd_chk(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    IOBUS_ADDR = addr;
    #1;
    chk(IOBUS_IN, exp, tag);
  endtask

  // Cycles until INTR (use_intr) or STATUS.PEND rises; 0 when the bound expires.
  task automatic wait_flag(input int maxc, input bit use_intr, output int k);
    k = 0;
    for (int c = 1; c <= maxc; c++) begin
      step(1'b0, BASE + 32'hC, 32'd0);
      if (use_intr ? INTR : IOBUS_IN[0]) begin
        k = c;
        break;
      end
    end
  endtask

  initial begin
    int k;
    logic [31:0] a, d;
    int sel, r;
    model_reset();

    // reset state, window decode
    #5;
    for (int o = 0; o < 16; o += 4) begin
      rd_chk(BASE + o, 32'd0, "rst_read");
      chk(32'(HIT), 32'd1, "rst_hit_in");
    end
    rd_chk(BASE + 32'h10, 32'd0, "rst_read_out");
    chk(32'(HIT), 32'd0, "rst_hit_10");
    IOBUS_ADDR = BASE - 32'h4; #1;
    chk(32'(HIT), 32'd0, "rst_hit_below");
    chk(32'(INTR), 32'd0, "rst_intr");
    #45 RESET = 1'b0;
    #2;
    for (int o = 0; o < 16; o += 4) rd_chk(BASE + o, 32'd0, "post_rst_read");
    chk(32'(INTR), 32'd0, "post_rst_intr");

    // one-shot, IE set: 16 cycles
    step(1, BASE + 32'h4, 32'd3);
    step(1, BASE + 32'h0, 32'd5);
    rd_chk(BASE + 32'h7, 32'd3, "load_subword");
    wait_flag(40, 1, k);
    chk(k, 16, "oneshot_latency");
    rd_chk(BASE + 32'h0, 32'd4, "oneshot_ctrl");
    rd_chk(BASE + 32'h8, 32'd0, "oneshot_count");
    idle(3);
    rd_chk(BASE + 32'h8, 32'd0, "oneshot_count_hold");
    step(1, BASE + 32'h0, 32'd0);
    step(1, BASE + 32'hC, 32'd1);
    chk(32'(INTR), 32'd0, "oneshot_clear");

    // auto-reload: period 12, COUNT 2,1,0,2
    step(1, BASE + 32'h4, 32'd2);
    step(1, BASE + 32'h0, 32'd7);
    for (int c = 1; c <= 12; c++) begin
      step(1'b0, BASE + 32'h8, 32'd0);
      if (c == 3)  chk(IOBUS_IN, 32'd2, "auto_count_c3");
      if (c == 4)  chk(IOBUS_IN, 32'd1, "auto_count_c4");
      if (c == 8)  chk(IOBUS_IN, 32'd0, "auto_count_c8");
      if (c == 11) chk(32'(INTR), 32'd0, "auto_intr_c11");
      if (c == 12) begin
        chk(IOBUS_IN, 32'd2, "auto_count_reload");
        chk(32'(INTR), 32'd1, "auto_intr_c12");
      end
    end
    step(1, BASE + 32'hC, 32'd1);
    chk(32'(INTR), 32'd0, "auto_w1c");
    wait_flag(20, 1, k);
    chk(k, 11, "auto_second_period");
    step(1, BASE + 32'h0, 32'd0);
    step(1, BASE + 32'hC, 32'd1);

    // pause/resume with IE=0
    step(1, BASE + 32'h4, 32'd5);
    step(1, BASE + 32'h0, 32'd1);
    idle(7);
    step(1, BASE + 32'h0, 32'd0);
    rd_chk(BASE + 32'h8, 32'd3, "pause_count");
    idle(20);
    rd_chk(BASE + 32'h8, 32'd3, "pause_count_hold");
    rd_chk(BASE + 32'hC, 32'd0, "pause_pend");
    step(1, BASE + 32'h0, 32'd1);
    wait_flag(30, 0, k);
    chk(k, 16, "resume_latency");
    chk(32'(INTR), 32'd0, "resume_intr_masked");
    rd_chk(BASE + 32'h0, 32'd0, "resume_en_cleared");
    step(1, BASE + 32'hC, 32'd1);

    // W1C on the expiry edge: set wins
    step(1, BASE + 32'h4, 32'd1);
    step(1, BASE + 32'h0, 32'd1);
    idle(7);
    step(1, BASE + 32'hC, 32'd1);
    rd_chk(BASE + 32'hC, 32'd1, "w1c_vs_expire");
    rd_chk(BASE + 32'h0, 32'd0, "w1c_vs_expire_ctrl");
    step(1, BASE + 32'hC, 32'd1);
    rd_chk(BASE + 32'hC, 32'd0, "w1c_after");

    // async reset mid-count
    step(1, BASE + 32'h4, 32'd3);
    step(1, BASE + 32'h0, 32'd5);
    idle(5);
    rd_chk(BASE + 32'h8, 32'd2, "pre_reset_count");
    #2 RESET = 1'b1;
    model_reset();
    for (int o = 0; o < 16; o += 4) rd_chk(BASE + o, 32'd0, "async_reset_read");
    chk(32'(INTR), 32'd0, "async_reset_intr");
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step(1'b0, BASE + 32'hC, 32'd0);
      chk(32'(INTR), 32'd0, "post_reset_intr");
    end
    rd_chk(BASE + 32'hC, 32'd0, "post_reset_pend");
    rd_chk(BASE + 32'h8, 32'd0, "post_reset_count");

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      r   = $urandom_range(0, 9);
      sel = $urandom_range(0, 4);
      a   = BASE + sel * 4 + $urandom_range(0, 3);
      case (sel)
        1:       d = $urandom_range(0, 6);
        default: d = $urandom();
      endcase
      if (r < 4) step(1'b0, a, d);
      else       step(1'b1, a, d);
      chk(32'(INTR), 32'(m_pend & m_ie), "rand_intr");
      sel = $urandom_range(0, 4);
      a   = BASE + sel * 4 + $urandom_range(0, 3);
      IOBUS_ADDR = a; #1;
      chk(IOBUS_IN, model_read(a), "rand_read");
      chk(32'(HIT), (sel < 4) ? 32'd1 : 32'd0, "rand_hit");
      if (i == 200) begin
        #1 RESET = 1'b1;
        model_reset();
        #1;
        chk(32'(INTR), 32'd0, "rand_reset_intr");
        @(negedge CLK);
        RESET = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
